// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
//
// Purpose : state encoding and frame constants used by prog_loader and its helpers.
// Ports   : none (package).

package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_STATUS
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         LEN_BYTES = 4;
   localparam int         LEN_CNTW  = $clog2(LEN_BYTES);

   // True while the loader is inside a frame and waiting on upstream bytes.
   function automatic logic waits_for_byte(input state_t st);
      return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_wdt.sv
// rtl/prog_loader_wdt.sv - inter-byte timeout counter for the program loader
//
// Purpose : counts idle cycles while enabled; flags expiry once TIMEOUT_CYCLES idle
//           cycles have elapsed since the last clear.
// Ports   : clk     - system clock
//           rst     - asynchronous active-high reset
//           clr     - clear the count (byte accepted, or loader not mid-frame)
//           en      - count this cycle
//           expired - count has reached TIMEOUT_CYCLES

module prog_loader_wdt #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates at the limit so a stalled enable cannot wrap back to "fresh".
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader driving the program RAM write port
//
// Purpose : parses A5 | LEN(4, little-endian) | payload | CSUM from an upstream byte source,
//           writes payload bytes to RAM addresses 0.., holds the CPU until a load succeeds.
// Ports   : clk, rst             - clock, asynchronous active-high reset
//           rx_valid/rx_data     - upstream byte offer
//           rx_ready             - byte consumed when rx_valid && rx_ready
//           ram_we/ram_addr/ram_din - registered RAM byte write port (one-cycle strobe)
//           cpu_hold             - keep CPU in reset / off the RAM
//           busy                 - frame in progress
//           done                 - one-cycle pulse on successful load
//           err                  - sticky failure flag, cleared by the next sync byte

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned MEM_SIZE       = 32767,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          HOLD_AT_RESET  = 1'b1,
   localparam int         ADDRW          = $clog2(MEM_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   output logic             ram_we,
   output logic [ADDRW-1:0] ram_addr,
   output logic [7:0]       ram_din,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [LEN_CNTW-1:0] LEN_LAST = LEN_CNTW'(LEN_BYTES - 1);

   state_t                state_q, state_d;
   logic [31:0]           len_q, len_d;
   logic [LEN_CNTW-1:0]   bcnt_q, bcnt_d;
   logic [ADDRW:0]        idx_q, idx_d;
   logic [7:0]            csum_q, csum_d;
   logic                  ok_q, ok_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDRW-1:0]      ram_addr_q, ram_addr_d;
   logic [7:0]            ram_din_q, ram_din_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic [31:0]           full_len;
   logic [ADDRW:0]        idx_next;
   logic                  wdt_clr;
   logic                  wdt_en;
   logic                  wdt_expired;

   assign rx_ready = (state_q != ST_STATUS);
   assign accept   = rx_valid && rx_ready;
   // Length arrives LSB first; the incoming byte lands in the top lane.
   assign full_len = {rx_data, len_q[31:8]};
   assign idx_next = idx_q + (ADDRW + 1)'(1);

   assign wdt_en  = waits_for_byte(state_q);
   assign wdt_clr = accept || !wdt_en;

   prog_loader_wdt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clr     (wdt_clr),
      .en      (wdt_en),
      .expired (wdt_expired)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      bcnt_d     = bcnt_q;
      idx_d      = idx_q;
      csum_d     = csum_q;
      ok_d       = ok_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_d    = ST_LEN;
               err_d      = 1'b0;
               cpu_hold_d = 1'b1;
               len_d      = '0;
               bcnt_d     = '0;
               idx_d      = '0;
               csum_d     = '0;
               ok_d       = 1'b0;
            end
         end

         ST_LEN: begin
            if (accept) begin
               len_d  = full_len;
               bcnt_d = bcnt_q + LEN_CNTW'(1);
               if (bcnt_q == LEN_LAST) begin
                  if (full_len > MEM_SIZE) begin
                     state_d = ST_STATUS;
                     ok_d    = 1'b0;
                  end else if (full_len == 32'd0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end else if (wdt_expired) begin
               state_d = ST_STATUS;
               ok_d    = 1'b0;
            end
         end

         ST_DATA: begin
            if (accept) begin
               ram_we_d   = 1'b1;
               ram_addr_d = idx_q[ADDRW-1:0];
               ram_din_d  = rx_data;
               csum_d     = csum_q + rx_data;
               idx_d      = idx_next;
               // LEN was bounded by MEM_SIZE, so its low ADDRW+1 bits hold it exactly.
               if (idx_next == len_q[ADDRW:0]) begin
                  state_d = ST_CSUM;
               end
            end else if (wdt_expired) begin
               state_d = ST_STATUS;
               ok_d    = 1'b0;
            end
         end

         ST_CSUM: begin
            if (accept) begin
               state_d = ST_STATUS;
               ok_d    = (rx_data == csum_q);
            end else if (wdt_expired) begin
               state_d = ST_STATUS;
               ok_d    = 1'b0;
            end
         end

         ST_STATUS: begin
            state_d = ST_IDLE;
            if (ok_q) begin
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         bcnt_q     <= '0;
         idx_q      <= '0;
         csum_q     <= '0;
         ok_q       <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         cpu_hold_q <= HOLD_AT_RESET;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         bcnt_q     <= bcnt_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         ok_q       <= ok_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
